multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the minimal RISC-V core; the block that drives the datapath one phase at a time.
- Sequences fetch, decode, execute, memory and writeback, and handles valid/ready handshakes with instruction and data memory.
- Drives register file, immediate generator, ALU, PC and IR control strobes.
- Supports ld, sd, R-type (add/sub/and/or) and beq. Any other opcode halts the core.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for ready before trapping.
- RETIRE_CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- instruction  in  INSTRUCTION_WIDTH  IR contents (decoded after ir_write)
- alu_zero  in  1  ALU zero flag (beq compare)
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_read  out  1  data memory read request
- dmem_write  out  1  data memory write request
- ir_write  out  1  latch fetched word into IR
- pc_write  out  1  update PC
- pc_src  out  1  0: PC+4, 1: PC+offset
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source (1 = memory data)
- alu_src  out  1  ALU B operand (1 = immediate)
- alu_op  out  alu_op_t  ALU operation
- retire  out  1  one-cycle pulse per completed instruction
- retired_count  out  RETIRE_CNT_WIDTH  retired instruction count
- halted  out  1  sticky trap indicator

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to FETCH.
  - All outputs go to 0 (alu_op = ALU_ADD), retired_count = 0, halted = 0, timeout counter = 0.
  - Asserting rst mid-instruction abandons it: no pc_write, reg_write or retire.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Registered state; outputs decoded from state plus the latched opcode (Moore-style, except the handshake-qualified strobes noted below).
- FETCH:
  - imem_req = 1 until imem_ready.
  - In the imem_ready cycle: ir_write = 1, then go to DECODE.
- DECODE: one cycle for register read and immediate generation.
  - Opcode 0110011, 0000011 (funct3 011), 0100011 (funct3 011) or 1100011 (funct3 000): go to EXECUTE.
  - Anything else: go to TRAP.
- EXECUTE:
  - R-type: alu_src = 0, alu_op from funct3/funct7[5]; go to WRITEBACK.
  - ld/sd: alu_src = 1, alu_op = ALU_ADD; go to MEM.
  - beq: alu_src = 0, alu_op = ALU_SUB, pc_write = 1, pc_src = alu_zero, retire = 1; go to FETCH.
- MEM:
  - ld: dmem_read = 1 until dmem_ready, then go to WRITEBACK.
  - sd: dmem_write = 1 until dmem_ready. In the dmem_ready cycle: pc_write = 1, pc_src = 0, retire = 1; go to FETCH.
- WRITEBACK: reg_write = 1, mem_to_reg = (ld), pc_write = 1, pc_src = 0, retire = 1; go to FETCH.
- Latency from entering FETCH with imem_ready already high:
  - beq = 3 cycles
  - R-type = 4 cycles
  - sd = 4 cycles
  - ld = 5 cycles
- Timeout counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle a request is held without ready.
  - When it reaches MEM_TIMEOUT without ready: go to TRAP.
  - A ready arriving in the same cycle the limit is reached wins; no trap.
- TRAP: all strobes 0, halted = 1. Exit only by reset.
- retired_count: increments on each retire pulse and wraps modulo 2^RETIRE_CNT_WIDTH.
- Registers x0 handling and immediate sign extension are datapath concerns, outside this block.

Decomposition:
- common_pkg additions:
  - ctrl_state_t enum
  - alu_op_t enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
  - Opcode constants: OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_RTYPE = 7'b0110011, OPC_BRANCH = 7'b1100011
  - FUNCT3_D = 3'b011, FUNCT3_BEQ = 3'b000
- One sub-module: alu_decoder (combinational; opcode/funct3/funct7 to alu_op_t), reusable elsewhere.

Test Plan:
- R-type 0x00820833, imem_ready held high: reg_write high exactly in cycle 4, alu_op = ALU_ADD, retire in cycle 4, retired_count = 1.
- ld 0x00F23403, dmem_ready after 3 wait cycles: dmem_read high 4 cycles, then WRITEBACK with mem_to_reg = 1, reg_write = 1; total 8 cycles.
- sd 0x828237A3: dmem_write held until dmem_ready; reg_write never asserted; pc_write with pc_src = 0 in the ready cycle.
- beq 0xA4820F63 with alu_zero = 1, then again with alu_zero = 0: pc_write in cycle 3 with pc_src = 1, then pc_src = 0; reg_write never asserted.
- Illegal word 0x00000000: TRAP after DECODE, halted = 1 sticky over 20 cycles, no further imem_req. Then assert rst: halted = 0, state FETCH.
- Hold dmem_ready low for a ld: halted after MEM_TIMEOUT = 16 wait cycles. Assert rst mid-MEM in a separate run: all strobes drop immediately and retired_count = 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package multicycle_control_pkg;

  localparam int INSTRUCTION_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_D   = 3'b011;
  localparam logic [2:0] FUNCT3_BEQ = 3'b000;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  // Instruction kind, latched in DECODE so later phases do not depend on IR.
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_ILLEGAL = 3'd4
  } instr_class_t;

  // Map opcode/funct3 onto the supported instruction kinds; all else is illegal.
  function automatic instr_class_t classify(input logic [6:0] opcode,
                                            input logic [2:0] funct3);
    instr_class_t cls;
    case (opcode)
      OPC_RTYPE:  cls = CLS_RTYPE;
      OPC_LOAD:   cls = (funct3 == FUNCT3_D)   ? CLS_LOAD   : CLS_ILLEGAL;
      OPC_STORE:  cls = (funct3 == FUNCT3_D)   ? CLS_STORE  : CLS_ILLEGAL;
      OPC_BRANCH: cls = (funct3 == FUNCT3_BEQ) ? CLS_BRANCH : CLS_ILLEGAL;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the sequencer (master) and the datapath/memories (slave).
interface multicycle_control_if #(
  parameter int RETIRE_CNT_WIDTH = 32
);
  import multicycle_control_pkg::*;

  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         alu_zero;
  logic                         imem_ready;
  logic                         dmem_ready;
  logic                         imem_req;
  logic                         dmem_read;
  logic                         dmem_write;
  logic                         ir_write;
  logic                         pc_write;
  logic                         pc_src;
  logic                         reg_write;
  logic                         mem_to_reg;
  logic                         alu_src;
  alu_op_t                      alu_op;
  logic                         retire;
  logic [RETIRE_CNT_WIDTH-1:0]  retired_count;
  logic                         halted;

  modport master (
    input  instruction, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_read, dmem_write, ir_write, pc_write, pc_src,
           reg_write, mem_to_reg, alu_src, alu_op, retire, retired_count, halted
  );

  modport slave (
    output instruction, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_read, dmem_write, ir_write, pc_write, pc_src,
           reg_write, mem_to_reg, alu_src, alu_op, retire, retired_count, halted
  );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: opcode/funct3/funct7[5] to alu_op_t (combinational).
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_op
);

  // Select the ALU function; unsupported encodings fall back to ADD.
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OPC_RTYPE: begin
        case (funct3)
          3'b000:  alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_BRANCH: alu_op = ALU_SUB;
      OPC_LOAD:   alu_op = ALU_ADD;
      OPC_STORE:  alu_op = ALU_ADD;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: fetch/decode/execute/mem/writeback with memory
// handshakes, a per-request timeout and a sticky trap state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT      = 16,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t                 state_r;
  ctrl_state_t                 state_next_s;
  instr_class_t                cls_r;
  instr_class_t                cls_s;
  alu_op_t                     alu_op_r;
  alu_op_t                     dec_alu_op_s;
  logic [CNT_W-1:0]            wait_cnt_r;
  logic                        waiting_s;
  logic                        timed_out_s;
  logic [RETIRE_CNT_WIDTH-1:0] retired_count_r;

  logic    imem_req_s, dmem_read_s, dmem_write_s, ir_write_s, pc_write_s;
  logic    pc_src_s, reg_write_s, mem_to_reg_s, alu_src_s, retire_s, halted_s;
  alu_op_t alu_op_s;

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_fields_s;
  assign unused_fields_s = ^{bus.instruction[31], bus.instruction[29:15],
                             bus.instruction[11:7]};

  assign cls_s = classify(bus.instruction[6:0], bus.instruction[14:12]);

  alu_decoder u_alu_decoder (
    .opcode   (bus.instruction[6:0]),
    .funct3   (bus.instruction[14:12]),
    .funct7_5 (bus.instruction[30]),
    .alu_op   (dec_alu_op_s)
  );

  assign waiting_s   = ((state_r == FETCH) && !bus.imem_ready) ||
                       ((state_r == MEM)   && !bus.dmem_ready);
  assign timed_out_s = waiting_s && (wait_cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        if (bus.imem_ready) begin
          state_next_s = DECODE;
        end else if (timed_out_s) begin
          state_next_s = TRAP;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        if (cls_s == CLS_ILLEGAL) begin
          state_next_s = TRAP;
        end else begin
          state_next_s = EXECUTE;
        end
      end
      EXECUTE: begin
        case (cls_r)
          CLS_RTYPE:  state_next_s = WRITEBACK;
          CLS_LOAD:   state_next_s = MEM;
          CLS_STORE:  state_next_s = MEM;
          CLS_BRANCH: state_next_s = FETCH;
          default:    state_next_s = TRAP;
        endcase
      end
      MEM: begin
        if (bus.dmem_ready) begin
          state_next_s = (cls_r == CLS_LOAD) ? WRITEBACK : FETCH;
        end else if (timed_out_s) begin
          state_next_s = TRAP;
        end else begin
          state_next_s = MEM;
        end
      end
      WRITEBACK: state_next_s = FETCH;
      TRAP:      state_next_s = TRAP;
      default:   state_next_s = TRAP;
    endcase
  end

  // Latch instruction kind and ALU function while in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_r    <= CLS_ILLEGAL;
      alu_op_r <= ALU_ADD;
    end else if (state_r == DECODE) begin
      cls_r    <= cls_s;
      alu_op_r <= dec_alu_op_s;
    end
  end

  // Wait counter: restarts on every state change, counts unanswered requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_next_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (waiting_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count_r <= '0;
    end else if (retire_s) begin
      retired_count_r <= retired_count_r + RETIRE_CNT_WIDTH'(1);
    end
  end

  // Output decode from state and latched kind; all strobes held low in reset.
  always_comb begin
    imem_req_s   = 1'b0;
    dmem_read_s  = 1'b0;
    dmem_write_s = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_s    = 1'b0;
    alu_op_s     = ALU_ADD;
    retire_s     = 1'b0;
    halted_s     = 1'b0;
    if (!rst) begin
      case (state_r)
        FETCH: begin
          imem_req_s = 1'b1;
          ir_write_s = bus.imem_ready;
        end
        DECODE: begin
          alu_op_s = ALU_ADD;
        end
        EXECUTE: begin
          case (cls_r)
            CLS_RTYPE: begin
              alu_src_s = 1'b0;
              alu_op_s  = alu_op_r;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src_s = 1'b1;
              alu_op_s  = ALU_ADD;
            end
            CLS_BRANCH: begin
              alu_src_s  = 1'b0;
              alu_op_s   = ALU_SUB;
              pc_write_s = 1'b1;
              pc_src_s   = bus.alu_zero;
              retire_s   = 1'b1;
            end
            default: alu_op_s = ALU_ADD;
          endcase
        end
        MEM: begin
          if (cls_r == CLS_LOAD) begin
            dmem_read_s = 1'b1;
          end else begin
            dmem_write_s = 1'b1;
            pc_write_s   = bus.dmem_ready;
            retire_s     = bus.dmem_ready;
          end
        end
        WRITEBACK: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = (cls_r == CLS_LOAD);
          pc_write_s   = 1'b1;
          retire_s     = 1'b1;
        end
        TRAP:    halted_s = 1'b1;
        default: halted_s = 1'b1;
      endcase
    end else begin
      halted_s = 1'b0;
    end
  end

  assign bus.imem_req      = imem_req_s;
  assign bus.dmem_read     = dmem_read_s;
  assign bus.dmem_write    = dmem_write_s;
  assign bus.ir_write      = ir_write_s;
  assign bus.pc_write      = pc_write_s;
  assign bus.pc_src        = pc_src_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.mem_to_reg    = mem_to_reg_s;
  assign bus.alu_src       = alu_src_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.retire        = retire_s;
  assign bus.retired_count = retired_count_r;
  assign bus.halted        = halted_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multicycle_control_if #(.RETIRE_CNT_WIDTH(32)) bus ();

  multicycle_control #(.MEM_TIMEOUT(16), .RETIRE_CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Leaves the DUT in cycle 1 of FETCH, just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.instruction = 32'h0000_0000;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.ir_write !== 1'b0 || bus.halted !== 1'b0 ||
        bus.retired_count !== 32'd0 || bus.alu_op !== ALU_ADD) begin
      failures++;
      $display("FAIL reset_outputs got req=%b irw=%b halt=%b cnt=%0d op=%0d exp 0/0/0/0/0",
               bus.imem_req, bus.ir_write, bus.halted, bus.retired_count, bus.alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.ir_write !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch got req=%b irw=%b exp 1/1", bus.imem_req, bus.ir_write);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] instrs [4];
    alu_op_t     ops    [4];
    instrs[0] = 32'h0082_0833; ops[0] = ALU_ADD;
    instrs[1] = 32'h4082_0833; ops[1] = ALU_SUB;
    instrs[2] = 32'h0082_7833; ops[2] = ALU_AND;
    instrs[3] = 32'h0082_6833; ops[3] = ALU_OR;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      bus.instruction = instrs[t];
      bus.imem_ready = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
        if (cyc > 1) @(negedge clk);
        #1;
        checks++;
        if (bus.reg_write !== (cyc == 4) || bus.retire !== (cyc == 4)) begin
          failures++;
          $display("FAIL rtype%0d_wb cyc=%0d got rw=%b ret=%b exp %b", t, cyc,
                   bus.reg_write, bus.retire, (cyc == 4));
        end
        if (cyc == 3) begin
          checks++;
          if (bus.alu_op !== ops[t] || bus.alu_src !== 1'b0) begin
            failures++;
            $display("FAIL rtype%0d_alu got op=%0d src=%b exp op=%0d src=0", t,
                     bus.alu_op, bus.alu_src, ops[t]);
          end
        end
        if (cyc == 4) begin
          checks++;
          if (bus.pc_write !== 1'b1 || bus.pc_src !== 1'b0 || bus.mem_to_reg !== 1'b0) begin
            failures++;
            $display("FAIL rtype%0d_pc got pcw=%b src=%b m2r=%b exp 1/0/0", t,
                     bus.pc_write, bus.pc_src, bus.mem_to_reg);
          end
        end
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.retired_count !== 32'd1 || bus.imem_req !== 1'b1) begin
        failures++;
        $display("FAIL rtype%0d_count got cnt=%0d req=%b exp 1/1", t,
                 bus.retired_count, bus.imem_req);
      end
    end
  endtask

  task automatic test_ld();
    int reads;
    reads = 0;
    do_reset();
    bus.instruction = 32'h00F2_3403;
    bus.imem_ready = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus.dmem_ready = (cyc == 7);
      #1;
      if (bus.dmem_read === 1'b1) reads++;
      checks++;
      if (bus.dmem_read !== (cyc >= 4 && cyc <= 7) || bus.reg_write !== (cyc == 8) ||
          bus.mem_to_reg !== (cyc == 8) || bus.alu_src !== (cyc == 3)) begin
        failures++;
        $display("FAIL ld_cycle cyc=%0d got rd=%b rw=%b m2r=%b src=%b", cyc,
                 bus.dmem_read, bus.reg_write, bus.mem_to_reg, bus.alu_src);
      end
    end
    checks++;
    if (reads != 4) begin
      failures++;
      $display("FAIL ld_read_len got %0d exp 4", reads);
    end
    @(negedge clk);
    bus.dmem_ready = 1'b0;
    #1;
    checks++;
    if (bus.retired_count !== 32'd1) begin
      failures++;
      $display("FAIL ld_count got %0d exp 1", bus.retired_count);
    end
  endtask

  task automatic test_sd();
    do_reset();
    bus.instruction = 32'h8282_37A3;
    bus.imem_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus.dmem_ready = (cyc == 6);
      #1;
      checks++;
      if (bus.dmem_write !== (cyc >= 4) || bus.pc_write !== (cyc == 6) ||
          bus.retire !== (cyc == 6) || bus.reg_write !== 1'b0 || bus.pc_src !== 1'b0) begin
        failures++;
        $display("FAIL sd_cycle cyc=%0d got wr=%b pcw=%b ret=%b rw=%b src=%b", cyc,
                 bus.dmem_write, bus.pc_write, bus.retire, bus.reg_write, bus.pc_src);
      end
    end
    @(negedge clk);
    bus.dmem_ready = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.retired_count !== 32'd1) begin
      failures++;
      $display("FAIL sd_next got req=%b cnt=%0d exp 1/1", bus.imem_req, bus.retired_count);
    end
  endtask

  task automatic test_back_to_back_beq();
    do_reset();
    bus.instruction = 32'hA482_0F63;
    bus.imem_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus.alu_zero = (cyc <= 3);
      #1;
      checks++;
      if (bus.pc_write !== (cyc == 3 || cyc == 6) || bus.reg_write !== 1'b0 ||
          bus.pc_src !== (cyc == 3)) begin
        failures++;
        $display("FAIL beq_cycle cyc=%0d got pcw=%b src=%b rw=%b", cyc,
                 bus.pc_write, bus.pc_src, bus.reg_write);
      end
      if (cyc == 3) begin
        checks++;
        if (bus.alu_op !== ALU_SUB || bus.retire !== 1'b1) begin
          failures++;
          $display("FAIL beq_exec got op=%0d ret=%b exp op=1 ret=1", bus.alu_op, bus.retire);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.retired_count !== 32'd2) begin
      failures++;
      $display("FAIL beq_count got %0d exp 2", bus.retired_count);
    end
  endtask

  task automatic test_illegal();
    int bad;
    bad = 0;
    do_reset();
    bus.instruction = 32'h0000_0000;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL illegal_decode got halted=%b exp 0", bus.halted);
    end
    for (int cyc = 3; cyc <= 22; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.retire !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL illegal_sticky bad_cycles=%0d exp 0", bad);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL illegal_rst got halted=%b req=%b exp 0/0", bus.halted, bus.imem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL illegal_refetch got req=%b halted=%b exp 1/0", bus.imem_req, bus.halted);
    end
  endtask

  task automatic test_timeout();
    // Fetch never answered: 16 request cycles, trap in cycle 17.
    do_reset();
    bus.imem_ready = 1'b0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      checks++;
      if (bus.halted !== (cyc == 17) || bus.imem_req !== (cyc <= 16)) begin
        failures++;
        $display("FAIL fetch_timeout cyc=%0d got halted=%b req=%b", cyc, bus.halted, bus.imem_req);
      end
    end
    // Load never answered: MEM cycles 4..19, trap in cycle 20.
    do_reset();
    bus.instruction = 32'h00F2_3403;
    bus.imem_ready = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      if (cyc >= 19) begin
        checks++;
        if (bus.halted !== (cyc == 20) || bus.dmem_read !== (cyc == 19)) begin
          failures++;
          $display("FAIL mem_timeout cyc=%0d got halted=%b rd=%b", cyc, bus.halted, bus.dmem_read);
        end
      end
    end
    // Ready on the last allowed wait cycle wins over the timeout.
    do_reset();
    bus.instruction = 32'h00F2_3403;
    bus.imem_ready = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus.dmem_ready = (cyc == 19);
      #1;
    end
    checks++;
    if (bus.halted !== 1'b0 || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1) begin
      failures++;
      $display("FAIL mem_ready_wins got halted=%b rw=%b m2r=%b exp 0/1/1",
               bus.halted, bus.reg_write, bus.mem_to_reg);
    end
    bus.dmem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.instruction = 32'hA482_0F63;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 4) bus.instruction = 32'h00F2_3403;
      #1;
    end
    checks++;
    if (bus.dmem_read !== 1'b1 || bus.retired_count !== 32'd1) begin
      failures++;
      $display("FAIL mid_before got rd=%b cnt=%0d exp 1/1", bus.dmem_read, bus.retired_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dmem_read !== 1'b0 || bus.pc_write !== 1'b0 || bus.reg_write !== 1'b0 ||
        bus.retire !== 1'b0 || bus.retired_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset got rd=%b pcw=%b rw=%b ret=%b cnt=%0d exp all 0",
               bus.dmem_read, bus.pc_write, bus.reg_write, bus.retire, bus.retired_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.instruction = 32'h0000_0000;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_ld();
    test_sd();
    test_back_to_back_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
